// File: rtl/hours_counter_pkg.sv
// ---------------------------------------------------------------------------
// hours_counter_pkg : shared time-of-day constants, FSM encodings, BCD helpers
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hours_counter_pkg;

    localparam int BCD_W        = 4;
    localparam int HOURS_MAX_24 = 23;
    localparam int HOURS_MAX_12 = 12;

    localparam int         ST_W   = 1;
    localparam logic [0:0] ST_RUN = 1'b0;
    localparam logic [0:0] ST_SET = 1'b1;

    // A digit pair is legal if it is valid BCD and inside the display range.
    function automatic logic hours_legal(input logic [BCD_W-1:0] tens,
                                         input logic [BCD_W-1:0] units,
                                         input logic             mode24);
        logic [7:0] value;
        value = ({4'd0, tens} * 8'd10) + {4'd0, units};
        if (units > 4'd9) begin
            return 1'b0;
        end
        if (mode24) begin
            return value <= 8'(HOURS_MAX_24);
        end
        return (value >= 8'd1) && (value <= 8'(HOURS_MAX_12));
    endfunction

    function automatic logic [BCD_W-1:0] rst_tens(input logic mode24);
        return mode24 ? 4'd0 : 4'd1;
    endfunction

    function automatic logic [BCD_W-1:0] rst_units(input logic mode24);
        return mode24 ? 4'd0 : 4'd2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect : multi-flop synchroniser with single-cycle rise pulse
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Reset high so an input already high at reset release is not seen as an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/hours_counter.sv
// ---------------------------------------------------------------------------
// hours_counter : BCD hours counter (24h or 12h AM/PM) with manual SET mode
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hours_counter
    import hours_counter_pkg::*;
#(
    parameter bit MODE_24H    = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hours_clk,
    input  logic             set_en,
    input  logic             set_inc,
    input  logic             set_dec,
    output logic [BCD_W-1:0] hours_tens,
    output logic [BCD_W-1:0] hours_units,
    output logic             pm,
    output logic             day_tick,
    output logic             setting
);

    logic [ST_W-1:0]  state_q, state_d;
    logic [BCD_W-1:0] tens_q, tens_d;
    logic [BCD_W-1:0] units_q, units_d;
    logic             pm_q, pm_d;
    logic             tick_q, tick_d;
    logic             adv, run, do_inc, do_dec, legal;

    sync_edge_detect #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (hours_clk),
        .rise_o  (adv)
    );

    always_comb begin
        state_d = set_en ? ST_SET : ST_RUN;
        run     = (state_q == ST_RUN);
        do_inc  = run ? adv : (set_inc & ~set_dec);
        do_dec  = ~run & set_dec & ~set_inc;
        legal   = hours_legal(tens_q, units_q, MODE_24H);
        tens_d  = tens_q;
        units_d = units_q;
        pm_d    = pm_q;
        tick_d  = 1'b0;

        if ((do_inc || do_dec) && !legal) begin
            tens_d  = rst_tens(MODE_24H);
            units_d = rst_units(MODE_24H);
            pm_d    = 1'b0;
        end else if (do_inc) begin
            if (MODE_24H) begin
                if (tens_q == 4'd2 && units_q == 4'd3) begin
                    tens_d  = 4'd0;
                    units_d = 4'd0;
                    tick_d  = run;
                end else if (units_q == 4'd9) begin
                    tens_d  = tens_q + 4'd1;
                    units_d = 4'd0;
                end else begin
                    units_d = units_q + 4'd1;
                end
            end else begin
                if (tens_q == 4'd1 && units_q == 4'd2) begin
                    tens_d  = 4'd0;
                    units_d = 4'd1;
                end else if (tens_q == 4'd1 && units_q == 4'd1) begin
                    // 11 -> 12 crosses noon/midnight; only 11PM -> 12AM starts a new day.
                    units_d = 4'd2;
                    pm_d    = ~pm_q;
                    tick_d  = run & pm_q;
                end else if (units_q == 4'd9) begin
                    tens_d  = 4'd1;
                    units_d = 4'd0;
                end else begin
                    units_d = units_q + 4'd1;
                end
            end
        end else if (do_dec) begin
            if (MODE_24H) begin
                if (tens_q == 4'd0 && units_q == 4'd0) begin
                    tens_d  = 4'd2;
                    units_d = 4'd3;
                end else if (units_q == 4'd0) begin
                    tens_d  = tens_q - 4'd1;
                    units_d = 4'd9;
                end else begin
                    units_d = units_q - 4'd1;
                end
            end else begin
                if (tens_q == 4'd0 && units_q == 4'd1) begin
                    tens_d  = 4'd1;
                    units_d = 4'd2;
                end else if (tens_q == 4'd1 && units_q == 4'd2) begin
                    units_d = 4'd1;
                    pm_d    = ~pm_q;
                end else if (units_q == 4'd0) begin
                    tens_d  = 4'd0;
                    units_d = 4'd9;
                end else begin
                    units_d = units_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            tens_q  <= rst_tens(MODE_24H);
            units_q <= rst_units(MODE_24H);
            pm_q    <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            pm_q    <= pm_d;
            tick_q  <= tick_d;
        end
    end

    assign hours_tens  = tens_q;
    assign hours_units = units_q;
    assign pm          = pm_q;
    assign day_tick    = tick_q;
    assign setting     = (state_q == ST_SET);

endmodule

`default_nettype wire

// File: tb/tb_hours_counter.sv
// ---------------------------------------------------------------------------
// tb_hours_counter : scoreboard bench driving a 24h and a 12h counter together
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hours_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hours_clk = 1'b1;
    logic       set_en = 1'b0;
    logic       set_inc = 1'b0;
    logic       set_dec = 1'b0;
    logic [3:0] t24, u24, t12, u12;
    logic       pm24, tk24, st24, pm12, tk12, st12;

    hours_counter #(.MODE_24H(1'b1), .SYNC_STAGES(2)) dut24 (
        .clk(clk), .reset(reset), .hours_clk(hours_clk), .set_en(set_en),
        .set_inc(set_inc), .set_dec(set_dec), .hours_tens(t24), .hours_units(u24),
        .pm(pm24), .day_tick(tk24), .setting(st24)
    );

    hours_counter #(.MODE_24H(1'b0), .SYNC_STAGES(2)) dut12 (
        .clk(clk), .reset(reset), .hours_clk(hours_clk), .set_en(set_en),
        .set_inc(set_inc), .set_dec(set_dec), .hours_tens(t12), .hours_units(u12),
        .pm(pm12), .day_tick(tk12), .setting(st12)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    // Reference model: hour of day 0..23, both displays derived from it.
    int h = 0;
    bit in_set = 1'b0;

    typedef struct {
        int cyc;
        int h;
        bit tick;
    } exp_s;

    exp_s q24[$];
    exp_s q12[$];

    // Packed as {tens[9:6], units[5:2], pm[1], tick[0]}.
    function automatic int enc24(input int hh, input bit tk);
        return ((hh / 10) << 6) | ((hh % 10) << 2) | int'(tk);
    endfunction

    function automatic int enc12(input int hh, input bit tk);
        int d;
        d = (hh % 12 == 0) ? 12 : hh % 12;
        return ((d / 10) << 6) | ((d % 10) << 2) | ((hh >= 12 ? 1 : 0) << 1) | int'(tk);
    endfunction

    task automatic cmp(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int c, input bit tk);
        exp_s e;
        e.cyc  = c;
        e.h    = h;
        e.tick = tk;
        q24.push_back(e);
        q12.push_back(e);
    endtask

    task automatic check_steady(input string nm);
        cmp({nm, "_24h"}, int'({t24, u24, pm24, tk24}), enc24(h, 1'b0));
        cmp({nm, "_12h"}, int'({t12, u12, pm12, tk12}), enc12(h, 1'b0));
        cmp({nm, "_setting"}, int'({st24, st12}), in_set ? 3 : 0);
        cmp({nm, "_pending"}, q24.size() + q12.size(), 0);
    endtask

    task automatic apply_reset(input string nm);
        reset = 1'b1;
        q24.delete();
        q12.delete();
        h = 0;
        in_set = 1'b0;
        set_en = 1'b0;
        #1;
        cmp({nm, "_24h"}, int'({t24, u24, pm24, tk24}), enc24(0, 1'b0));
        cmp({nm, "_12h"}, int'({t12, u12, pm12, tk12}), enc12(0, 1'b0));
        cmp({nm, "_setting"}, int'({st24, st12}), 0);
        step(2);
        reset = 1'b0;
    endtask

    task automatic hours_pulse(input int hi, input int lo);
        hours_clk = 1'b1;
        if (!in_set) begin
            h = (h + 1) % 24;
            push(cyc + 3, h == 0);
        end
        step(hi);
        hours_clk = 1'b0;
        step(lo);
    endtask

    task automatic set_mode(input bit en);
        set_en = en;
        step(2);
        in_set = en;
    endtask

    task automatic button(input bit inc, input bit dec);
        set_inc = inc;
        set_dec = dec;
        if (in_set && (inc != dec)) begin
            h = inc ? (h + 1) % 24 : (h + 23) % 24;
            push(cyc + 1, 1'b0);
        end
        step(1);
        set_inc = 1'b0;
        set_dec = 1'b0;
    endtask

    // Monitor: any digit change or day_tick must match the oldest expected update.
    int p24 = 0;
    int p12 = 0;
    always @(negedge clk) begin : mon
        int a24, a12;
        exp_s e;
        a24 = int'({t24, u24, pm24, tk24});
        a12 = int'({t12, u12, pm12, tk12});
        if (reset) begin
            p24 = a24 >> 1;
            p12 = a12 >> 1;
        end else begin
            if ((a24 >> 1) != p24 || tk24) begin
                if (q24.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL 24h_unexpected: got 0x%0h at cycle %0d, required no change", a24, cyc);
                end else begin
                    e = q24.pop_front();
                    cmp("24h_value", a24, enc24(e.h, e.tick));
                    cmp("24h_update_cycle", cyc, e.cyc);
                end
            end else if (q24.size() > 0 && q24[0].cyc < cyc) begin
                checks++;
                fails++;
                $display("FAIL 24h_missing: got no update by cycle %0d, required one at %0d", cyc, q24[0].cyc);
                e = q24.pop_front();
            end
            if ((a12 >> 1) != p12 || tk12) begin
                if (q12.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL 12h_unexpected: got 0x%0h at cycle %0d, required no change", a12, cyc);
                end else begin
                    e = q12.pop_front();
                    cmp("12h_value", a12, enc12(e.h, e.tick));
                    cmp("12h_update_cycle", cyc, e.cyc);
                end
            end else if (q12.size() > 0 && q12[0].cyc < cyc) begin
                checks++;
                fails++;
                $display("FAIL 12h_missing: got no update by cycle %0d, required one at %0d", cyc, q12[0].cyc);
                e = q12.pop_front();
            end
            p24 = a24 >> 1;
            p12 = a12 >> 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        // Reset with hours_clk high: release must not count.
        step(1);
        apply_reset("reset_hclk_high");
        step(10);
        check_steady("after_release");
        hours_clk = 1'b0;
        step(5);
        check_steady("after_fall");

        // A full day of pulses, 20-cycle period, including the midnight tick.
        repeat (24) hours_pulse(10, 10);
        check_steady("full_day");

        // SET: decrement through midnight, ignore hours_clk, clean exit.
        set_mode(1'b1);
        repeat (3) begin
            button(1'b0, 1'b1);
            step(1);
        end
        repeat (2) hours_pulse(3, 3);
        check_steady("set_frozen");
        set_mode(1'b0);
        step(5);
        check_steady("set_exit");

        // SET: simultaneous buttons at 09, single inc, inc ignored in RUN.
        apply_reset("reset_before_09");
        set_mode(1'b1);
        repeat (9) button(1'b1, 1'b0);
        button(1'b1, 1'b1);
        step(2);
        check_steady("both_buttons");
        button(1'b1, 1'b0);
        set_mode(1'b0);
        button(1'b1, 1'b0);
        step(2);
        check_steady("inc_in_run");

        // Reset between the hours_clk rise and its update edge.
        hours_clk = 1'b1;
        step(1);
        apply_reset("reset_mid_edge");
        step(10);
        hours_clk = 1'b0;
        step(5);
        check_steady("after_mid_reset");

        // Randomized mix of run pulses, SET sessions and ignored buttons.
        repeat (40) begin
            case ($urandom_range(0, 3))
                0, 1: hours_pulse(int'($urandom_range(2, 6)), int'($urandom_range(2, 6)));
                2: begin
                    set_mode(1'b1);
                    repeat ($urandom_range(1, 6)) begin
                        r = int'($urandom_range(0, 3));
                        if (r == 3) hours_pulse(2, 3);
                        else button(r != 1, r != 0);
                        step(int'($urandom_range(0, 2)));
                    end
                    step(4);
                    set_mode(1'b0);
                end
                default: button(1'b1, 1'($urandom_range(0, 1)));
            endcase
            step(4);
            check_steady("random");
        end

        step(10);
        cmp("final_pending", q24.size() + q12.size(), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

`default_nettype wire
